exe_stage: RTL and testbench

EXE_STAGE -- requirements
Module: exe_stage

---
 rtl/exe_stage.sv | 156 +++++++++++++++
 tb/tb_exe_stage.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
`default_nettype none
// ============================================================================
//  Module   : exe_stage
//  Purpose  : Pipeline EXE stage with multi-cycle divide handshake, flush/drain
//             handling and optional result forwarding (macro EXE_FWD_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module exe_stage #(
    parameter int SIDE_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ds_to_es_valid,
    input  logic [17:0]       ds_alu_op,
    input  logic [32:0]       ds_alu_src1,
    input  logic [32:0]       ds_alu_src2,
    input  logic [4:0]        ds_dest,
    input  logic              ds_gr_we,
    input  logic [SIDE_W-1:0] ds_side,
    output logic              es_allowin,
    output logic [17:0]       es_alu_op,
    output logic [32:0]       es_alu_src1,
    output logic [32:0]       es_alu_src2,
    input  logic [31:0]       alu_result,
    input  logic              div_valid,
    output logic              es_to_ms_valid,
    input  logic              ms_allowin,
    output logic [31:0]       es_result,
    output logic [4:0]        es_dest,
    output logic              es_gr_we,
    output logic [SIDE_W-1:0] es_side,
    input  logic              es_flush,
    output logic              es_fwd_we,
    output logic [4:0]        es_fwd_dest,
    output logic [31:0]       es_fwd_data,
    output logic              es_fwd_pending
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DONE  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_valid;
    logic              w_valid_nxt;
    logic              w_capture;
    logic [17:0]       r_alu_op;
    logic [32:0]       r_src1;
    logic [32:0]       r_src2;
    logic [4:0]        r_dest;
    logic              r_gr_we;
    logic [SIDE_W-1:0] r_side;
    logic [31:0]       r_res_q;

    logic w_is_div;
    logic w_ds_is_div;
    logic w_ready_go;
    logic w_load;
    logic w_handoff;

    assign w_is_div    = |r_alu_op[17:14];
    assign w_ds_is_div = |ds_alu_op[17:14];
    assign w_ready_go  = !w_is_div || ((r_state == S_BUSY) && div_valid) || (r_state == S_DONE);

    assign es_to_ms_valid = r_valid && w_ready_go && !es_flush;
    assign es_allowin     = (r_state != S_DRAIN) && (!r_valid || (w_ready_go && ms_allowin));
    assign w_load         = ds_to_es_valid && es_allowin && !es_flush;
    assign w_handoff      = es_to_ms_valid && ms_allowin;

    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_capture   = 1'b0;
        case (r_state)
            S_DRAIN: begin
                if (div_valid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                if (es_flush) begin
                    w_valid_nxt = 1'b0;
                    // A divide whose result lands this very cycle has nothing left to drain
                    w_state_nxt = ((r_state == S_BUSY) && !div_valid) ? S_DRAIN : S_IDLE;
                end else if (w_load) begin
                    w_valid_nxt = 1'b1;
                    w_state_nxt = w_ds_is_div ? S_BUSY : S_IDLE;
                end else if (w_handoff) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_IDLE;
                end else if ((r_state == S_BUSY) && div_valid) begin
                    w_state_nxt = S_DONE;
                    w_capture   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_valid  <= 1'b0;
            r_alu_op <= '0;
            r_src1   <= '0;
            r_src2   <= '0;
            r_dest   <= '0;
            r_gr_we  <= 1'b0;
            r_side   <= '0;
            r_res_q  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_valid_nxt;
            if (w_load) begin
                r_alu_op <= ds_alu_op;
                r_src1   <= ds_alu_src1;
                r_src2   <= ds_alu_src2;
                r_dest   <= ds_dest;
                r_gr_we  <= ds_gr_we;
                r_side   <= ds_side;
            end
            if (w_capture) begin
                r_res_q <= alu_result;
            end
        end
    end

    // Op is withdrawn in DONE so the divider re-arms; kept in DRAIN so it can finish
    assign es_alu_op = (r_state == S_DONE)  ? 18'd0    :
                       (r_state == S_DRAIN) ? r_alu_op :
                       (r_valid ? r_alu_op : 18'd0);

    assign es_alu_src1 = r_src1;
    assign es_alu_src2 = r_src2;
    assign es_result   = (r_state == S_DONE) ? r_res_q : alu_result;
    assign es_dest     = r_dest;
    assign es_gr_we    = r_gr_we;
    assign es_side     = r_side;

`ifdef EXE_FWD_EN
    assign es_fwd_we      = r_valid && r_gr_we;
    assign es_fwd_dest    = r_dest;
    assign es_fwd_data    = es_result;
    assign es_fwd_pending = r_valid && w_is_div && !w_ready_go;
`else
    assign es_fwd_we      = 1'b0;
    assign es_fwd_dest    = 5'd0;
    assign es_fwd_data    = 32'd0;
    assign es_fwd_pending = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_exe_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exe_stage
//  Purpose  : Directed self-checking bench for exe_stage with a stub ALU whose
//             divider answers DIV_LAT cycles after a divide op is presented.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_exe_stage;

    localparam int          SIDE_W  = 64;
    localparam logic [5:0]  DIV_LAT = 6'd20;
    localparam logic [17:0] OP_ADD  = 18'h00001;
    localparam logic [17:0] OP_DIV  = 18'h04000;
    localparam logic [17:0] OP_MOD  = 18'h08000;
    localparam logic [17:0] OP_DIVU = 18'h10000;
`ifdef EXE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              ds_to_es_valid = 1'b0;
    logic [17:0]       ds_alu_op = '0;
    logic [32:0]       ds_alu_src1 = '0;
    logic [32:0]       ds_alu_src2 = '0;
    logic [4:0]        ds_dest = '0;
    logic              ds_gr_we = 1'b0;
    logic [SIDE_W-1:0] ds_side = '0;
    logic              es_allowin;
    logic [17:0]       es_alu_op;
    logic [32:0]       es_alu_src1;
    logic [32:0]       es_alu_src2;
    logic [31:0]       alu_result;
    logic              div_valid;
    logic              es_to_ms_valid;
    logic              ms_allowin = 1'b1;
    logic [31:0]       es_result;
    logic [4:0]        es_dest;
    logic              es_gr_we;
    logic [SIDE_W-1:0] es_side;
    logic              es_flush = 1'b0;
    logic              es_fwd_we;
    logic [4:0]        es_fwd_dest;
    logic [31:0]       es_fwd_data;
    logic              es_fwd_pending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exe_stage #(.SIDE_W(SIDE_W)) dut (
        .clk(clk), .reset(reset),
        .ds_to_es_valid(ds_to_es_valid), .ds_alu_op(ds_alu_op),
        .ds_alu_src1(ds_alu_src1), .ds_alu_src2(ds_alu_src2),
        .ds_dest(ds_dest), .ds_gr_we(ds_gr_we), .ds_side(ds_side),
        .es_allowin(es_allowin), .es_alu_op(es_alu_op),
        .es_alu_src1(es_alu_src1), .es_alu_src2(es_alu_src2),
        .alu_result(alu_result), .div_valid(div_valid),
        .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
        .es_result(es_result), .es_dest(es_dest), .es_gr_we(es_gr_we),
        .es_side(es_side), .es_flush(es_flush),
        .es_fwd_we(es_fwd_we), .es_fwd_dest(es_fwd_dest),
        .es_fwd_data(es_fwd_data), .es_fwd_pending(es_fwd_pending)
    );

    // Stub ALU: add plus four divide flavours; divider counts while a divide op is held
    logic [5:0] div_cnt;
    logic       alu_is_div;
    assign alu_is_div = |es_alu_op[17:14];
    assign div_valid  = !alu_is_div || (div_cnt == DIV_LAT);

    always @(posedge clk) begin
        if (reset || !alu_is_div || (div_cnt == DIV_LAT)) div_cnt <= 6'd0;
        else div_cnt <= div_cnt + 6'd1;
    end

    always_comb begin
        alu_result = 32'd0;
        if (es_alu_op[0]) alu_result = es_alu_src1[31:0] + es_alu_src2[31:0];
        else if (es_alu_src2[31:0] == 32'd0) alu_result = 32'd0;
        else if (es_alu_op[14]) alu_result = $signed(es_alu_src1[31:0]) / $signed(es_alu_src2[31:0]);
        else if (es_alu_op[15]) alu_result = $signed(es_alu_src1[31:0]) % $signed(es_alu_src2[31:0]);
        else if (es_alu_op[16]) alu_result = es_alu_src1[31:0] / es_alu_src2[31:0];
        else if (es_alu_op[17]) alu_result = es_alu_src1[31:0] % es_alu_src2[31:0];
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [17:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
        ds_to_es_valid = 1'b1;
        ds_alu_op      = op;
        ds_alu_src1    = {1'b0, a};
        ds_alu_src2    = {1'b0, b};
        ds_dest        = d;
        ds_gr_we       = 1'b1;
        ds_side        = {32'hC0DE0000, 27'd0, d};
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (es_to_ms_valid !== 1'b0) begin errors++; $display("FAIL rst_to_ms: got %0b expected 0", es_to_ms_valid); end
        checks++; if (es_allowin !== 1'b1) begin errors++; $display("FAIL rst_allowin: got %0b expected 1", es_allowin); end
        checks++; if (es_alu_op !== 18'd0) begin errors++; $display("FAIL rst_alu_op: got %0h expected 0", es_alu_op); end
        checks++; if (es_alu_src1 !== 33'd0 || es_dest !== 5'd0 || es_side !== '0) begin
            errors++; $display("FAIL rst_regs: got src1 %0h dest %0d side %0h expected 0", es_alu_src1, es_dest, es_side); end
        checks++; if (es_fwd_we !== 1'b0 || es_fwd_pending !== 1'b0) begin
            errors++; $display("FAIL rst_fwd: got we %0b pend %0b expected 0", es_fwd_we, es_fwd_pending); end
        cyc();
    endtask

    task automatic test_back_to_back();
        logic [SIDE_W-1:0] exp_side;
        exp_side = {32'hC0DE0000, 27'd0, 5'd1};
        ms_allowin = 1'b1;
        drive(OP_ADD, 32'd3, 32'd4, 5'd1);
        @(negedge clk);
        checks++; if (es_allowin !== 1'b1) begin errors++; $display("FAIL b2b_allowin0: got %0b expected 1", es_allowin); end
        cyc();
        drive(OP_ADD, 32'd10, 32'd5, 5'd2);
        @(negedge clk);
        checks++; if (es_to_ms_valid !== 1'b1 || es_result !== 32'd7) begin
            errors++; $display("FAIL b2b_first: got valid %0b result %0d expected 1 7", es_to_ms_valid, es_result); end
        checks++; if (es_dest !== 5'd1 || es_side !== exp_side || es_allowin !== 1'b1) begin
            errors++; $display("FAIL b2b_first_ctl: got dest %0d side %0h allowin %0b expected 1 %0h 1", es_dest, es_side, es_allowin, exp_side); end
        checks++; if (es_fwd_we !== FWD || es_fwd_data !== (FWD ? 32'd7 : 32'd0)) begin
            errors++; $display("FAIL b2b_fwd: got we %0b data %0d expected %0b %0d", es_fwd_we, es_fwd_data, FWD, FWD ? 7 : 0); end
        cyc();
        ds_to_es_valid = 1'b0;
        @(negedge clk);
        checks++; if (es_to_ms_valid !== 1'b1 || es_result !== 32'd15 || es_dest !== 5'd2 || es_allowin !== 1'b1) begin
            errors++; $display("FAIL b2b_second: got valid %0b result %0d dest %0d allowin %0b expected 1 15 2 1", es_to_ms_valid, es_result, es_dest, es_allowin); end
        cyc();
        @(negedge clk);
        checks++; if (es_to_ms_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %0b expected 0", es_to_ms_valid); end
        cyc();
    endtask

    task automatic test_div();
        int n_valid, n_pend;
        logic [31:0] got;
        n_valid = 0; n_pend = 0; got = 32'd0;
        ms_allowin = 1'b1;
        drive(OP_DIV, 32'd100, 32'd7, 5'd3);
        cyc();
        ds_to_es_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (es_fwd_pending) n_pend++;
            if (es_to_ms_valid) begin n_valid++; got = es_result; end
            cyc();
        end
        checks++; if (n_valid != 1) begin errors++; $display("FAIL div_once: got %0d handoffs expected 1", n_valid); end
        checks++; if (got !== 32'd14) begin errors++; $display("FAIL div_result: got %0d expected 14", got); end
        checks++; if (n_pend != (FWD ? 20 : 0)) begin errors++; $display("FAIL div_pending: got %0d cycles expected %0d", n_pend, FWD ? 20 : 0); end
    endtask

    task automatic test_mod_stall();
        bit found;
        found = 1'b0;
        ms_allowin = 1'b0;
        drive(OP_MOD, 32'd100, 32'd7, 5'd4);
        cyc();
        ds_to_es_valid = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (es_to_ms_valid) found = 1'b1;
            else cyc();
        end
        checks++; if (!found || es_result !== 32'd2) begin
            errors++; $display("FAIL mod_complete: got found %0b result %0d expected 1 2", found, es_result); end
        cyc();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (es_to_ms_valid !== 1'b1 || es_result !== 32'd2) begin
                errors++; $display("FAIL mod_done_hold: got valid %0b result %0d expected 1 2", es_to_ms_valid, es_result); end
            checks++; if (es_alu_op !== 18'd0 || es_allowin !== 1'b0) begin
                errors++; $display("FAIL mod_done_op: got op %0h allowin %0b expected 0 0", es_alu_op, es_allowin); end
            cyc();
        end
        ms_allowin = 1'b1;
        @(negedge clk);
        checks++; if (es_to_ms_valid !== 1'b1 || es_allowin !== 1'b1 || es_result !== 32'd2) begin
            errors++; $display("FAIL mod_release: got valid %0b allowin %0b result %0d expected 1 1 2", es_to_ms_valid, es_allowin, es_result); end
        cyc();
        @(negedge clk);
        checks++; if (es_to_ms_valid !== 1'b0) begin errors++; $display("FAIL mod_after: got %0b expected 0", es_to_ms_valid); end
        cyc();
    endtask

    task automatic test_flush_idle();
        ms_allowin = 1'b1;
        drive(OP_ADD, 32'd1, 32'd1, 5'd7);
        cyc();
        drive(OP_ADD, 32'd2, 32'd2, 5'd8);
        es_flush = 1'b1;
        @(negedge clk);
        checks++; if (es_to_ms_valid !== 1'b0) begin errors++; $display("FAIL flush_idle_out: got %0b expected 0", es_to_ms_valid); end
        cyc();
        es_flush = 1'b0;
        ds_to_es_valid = 1'b0;
        @(negedge clk);
        checks++; if (es_to_ms_valid !== 1'b0) begin errors++; $display("FAIL flush_idle_ignored: got %0b expected 0", es_to_ms_valid); end
        cyc();
    endtask

    task automatic test_flush_drain();
        int n_drain, n_out, op_bad;
        bit done;
        logic [31:0] got;
        n_drain = 0; n_out = 0; op_bad = 0; done = 1'b0; got = 32'd0;
        ms_allowin = 1'b1;
        drive(OP_DIV, 32'd100, 32'd7, 5'd5);
        cyc();
        drive(OP_DIV, 32'd9, 32'd2, 5'd6);
        cyc();
        cyc();
        es_flush = 1'b1;
        @(negedge clk);
        checks++; if (es_to_ms_valid !== 1'b0) begin errors++; $display("FAIL drain_flush_out: got %0b expected 0", es_to_ms_valid); end
        cyc();
        es_flush = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (es_to_ms_valid) n_out++;
            if (es_allowin) done = 1'b1;
            else begin
                n_drain++;
                if (es_alu_op !== OP_DIV) op_bad++;
                cyc();
            end
        end
        checks++; if (!done || n_drain != 18) begin errors++; $display("FAIL drain_len: got %0d cycles expected 18", n_drain); end
        checks++; if (n_out != 0) begin errors++; $display("FAIL drain_out: got %0d handoffs expected 0", n_out); end
        checks++; if (op_bad != 0) begin errors++; $display("FAIL drain_op_held: got %0d bad cycles expected 0", op_bad); end
        cyc();
        ds_to_es_valid = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (es_to_ms_valid) begin done = 1'b1; got = es_result; end
            cyc();
        end
        checks++; if (!done || got !== 32'd4) begin errors++; $display("FAIL drain_next_div: got done %0b result %0d expected 1 4", done, got); end
    endtask

    task automatic test_flush_at_completion();
        bit idle;
        idle = 1'b0;
        ms_allowin = 1'b1;
        drive(OP_DIV, 32'd20, 32'd5, 5'd11);
        cyc();
        ds_to_es_valid = 1'b0;
        repeat (20) cyc();
        es_flush = 1'b1;
        @(negedge clk);
        checks++; if (es_to_ms_valid !== 1'b0) begin errors++; $display("FAIL flush_prio: got %0b expected 0", es_to_ms_valid); end
        cyc();
        es_flush = 1'b0;
        for (int i = 0; i < 40 && !idle; i++) begin
            @(negedge clk);
            if (es_allowin) idle = 1'b1;
            cyc();
        end
        checks++; if (!idle) begin errors++; $display("FAIL flush_prio_recover: got allowin 0 expected 1"); end
    endtask

    task automatic test_reset_mid_busy();
        bit done;
        logic [31:0] got;
        done = 1'b0; got = 32'd0;
        ms_allowin = 1'b1;
        drive(OP_DIV, 32'd100, 32'd7, 5'd9);
        cyc();
        ds_to_es_valid = 1'b0;
        repeat (5) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (es_to_ms_valid !== 1'b0 || es_allowin !== 1'b1 || es_alu_op !== 18'd0 || es_fwd_pending !== 1'b0) begin
            errors++; $display("FAIL rst_busy: got valid %0b allowin %0b op %0h pend %0b expected 0 1 0 0", es_to_ms_valid, es_allowin, es_alu_op, es_fwd_pending); end
        cyc();
        drive(OP_DIVU, 32'hFFFFFFFF, 32'd16, 5'd10);
        cyc();
        ds_to_es_valid = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (es_to_ms_valid) begin done = 1'b1; got = es_result; end
            cyc();
        end
        checks++; if (!done || got !== 32'h0FFFFFFF) begin errors++; $display("FAIL udiv_after_rst: got done %0b result %0h expected 1 0fffffff", done, got); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_div();
        test_mod_stall();
        test_flush_idle();
        test_flush_drain();
        test_flush_at_completion();
        test_reset_mid_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
